lane_packer: RTL and testbench
==============================

Name: lane_packer

Overview:
- Sequential, parametrised successor to the combinational byte-lane insert used in the SIMD AES datapath.
- Builds a LANES x LANE_W word one lane per beat, over a valid/ready stream.
- Supports two beat modes: sequential append or indexed insert over a preloaded base word.
- Presents the assembled word on a valid/ready output, e.g. for assembling state columns ahead of the SIMD AES round units.

Parameters:
- LANE_W, 8: bits per lane.
- LANES, 4: lanes per word; power of two, >= 2.
- IDX_W, $clog2(LANES): lane index width (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- base_load  in  1  load base_word as the background word.
- base_word  in  LANES*LANE_W  background word ("original" value).
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  LANE_W  lane payload.
- in_idx  in  IDX_W  target lane (mode 1 only).
- in_mode  in  1  0 = append at internal pointer, 1 = insert at in_idx.
- in_last  in  1  close word after this beat even if lanes remain unwritten.
- out_valid  out  1  assembled word available.
- out_ready  in  1  consumer accepts word.
- out_word  out  LANES*LANE_W  assembled word; lane k = bits [k*LANE_W +: LANE_W].
- out_mask  out  LANES  lanes written since last drain.
- dup_err  out  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Registers: word_q, mask_q, ptr_q (IDX_W bits), state in {EMPTY, FILL, HOLD}.
- Reset (async, rst_n=0): word_q=0, mask_q=0, ptr_q=0, state=EMPTY, out_valid=0, in_ready=0 during reset, dup_err=0. Reset mid-word discards all partial data.
- in_ready = (state != HOLD), combinational from state only.
- out_valid = (state == HOLD). out_word = word_q; out_mask = mask_q.
- Accepted beat, lane L:
  - L = ptr_q if in_mode=0; L = in_idx if in_mode=1.
  - word_q lane L <= in_data; mask_q[L] <= 1. All other lanes are unchanged.
  - ptr_q <= ptr_q+1 (mod LANES) only in mode 0.
- base_load, honoured in EMPTY/FILL only:
  - word_q <= base_word; mask_q and ptr_q unchanged.
  - Same cycle as an accepted beat: the beat lane is applied on top of base_word.
  - Ignored in HOLD.
- Transitions:
  - EMPTY -> FILL on an accepted beat, unless completion is reached on that beat.
  - FILL/EMPTY -> HOLD on an accepted beat where (mask_q | lane bit) is all ones, or in_last=1.
  - HOLD -> EMPTY when out_ready=1. On that edge: mask_q <= 0, ptr_q <= 0. word_q is retained as the background for the next word.
- Latency: out_valid rises the cycle after the completing beat is accepted. Throughput is at most one word per LANES+1 cycles (HOLD blocks input).
- Mode 1 duplicate index overwrites the lane; mask is unchanged; it is not a completion.
- Mode 0 pointer landing on a lane already set by mode 1 overwrites that lane.
- Mixed modes within one word are legal.
- out_word and out_mask are stable throughout HOLD regardless of inputs.
- Single-beat word with in_last: HOLD with exactly one mask bit set.

Optional Feature:
- Macro LANE_PACKER_DUP_ERR_EN.
- Defined: dup_err is a sticky register, set the cycle after any accepted beat whose target lane already has mask_q[L]=1. It is cleared only by reset. Data behaviour is unchanged.
- Undefined: dup_err is constant 0 and no detection logic is built.

Test Plan:
- Append fill, defaults: beats 0x11,0x22,0x33,0x44 in mode 0 -> out_valid one cycle after 4th beat, out_word=0x44332211, out_mask=4'hF, in_ready=0 until out_ready.
- Insert over base: base_load with 0xAABBCCDD, then mode 1 beat idx=2 data=0x5A with in_last=1 -> out_word=0xAA5ACCDD, out_mask=4'b0100.
- Backpressure: hold out_ready=0 for 5 cycles after completion and drive beats -> no beat accepted, word stable; out_ready=1 -> EMPTY, ptr=0, next append writes lane 0.
- Simultaneous: base_load=0x01020304 with mode 1 beat idx=0 data=0xFF in same cycle, in_last=1 -> out_word=0x010203FF.
- Duplicate: mode 1 idx=1 twice (0x10 then 0x20) -> lane 1=0x20, mask=4'b0010. dup_err=1 only with LANE_PACKER_DUP_ERR_EN.
- Reset mid-word: two beats accepted, pulse rst_n low asynchronously -> all outputs 0 immediately. LANE_W=16, LANES=8 regression: 8 appends of 0x0001..0x0008 -> out_word=0x0008000700060005000400030002_0001.

Source files
------------

// File: rtl/lane_packer.sv
`default_nettype none
// ============================================================================
// Module      : lane_packer
// Description : Assembles a LANES x LANE_W word one lane per input beat. Each
//               beat either appends at an internal pointer or inserts at an
//               explicit index over a loadable background word. Optional
//               sticky duplicate-lane flag under LANE_PACKER_DUP_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_packer #(
  parameter  int LANE_W = 8,
  parameter  int LANES  = 4,
  localparam int IDX_W  = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    base_load,
  input  logic [LANES*LANE_W-1:0] base_word,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANE_W-1:0]       in_data,
  input  logic [IDX_W-1:0]        in_idx,
  input  logic                    in_mode,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_word,
  output logic [LANES-1:0]        out_mask,
  output logic                    dup_err
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_out_valid;
  logic [LANES*LANE_W-1:0] r_word;
  logic [LANES-1:0]        r_mask;
  logic [IDX_W-1:0]        r_ptr;

  logic [IDX_W-1:0]        w_lane;
  logic [LANES-1:0]        w_lane_bit;
  logic [LANES-1:0]        w_mask_nxt;
  logic [LANES*LANE_W-1:0] w_bg;
  logic [LANES*LANE_W-1:0] w_word_nxt;
  logic                    w_accept;
  logic                    w_done;

  // Gated by rst_n so the stream stalls while reset is asserted.
  assign in_ready  = rst_n && (r_state != S_HOLD);
  assign out_valid = r_out_valid;
  assign out_word  = r_word;
  assign out_mask  = r_mask;

  always_comb begin
    w_lane     = in_mode ? in_idx : r_ptr;
    w_lane_bit = LANES'(1) << w_lane;
    w_mask_nxt = r_mask | w_lane_bit;
    w_accept   = in_valid && in_ready;
    w_done     = w_accept && ((&w_mask_nxt) || in_last);
    // A same-cycle base load becomes the background under the beat's lane.
    w_bg       = base_load ? base_word : r_word;
    w_word_nxt = w_bg;
    for (int k = 0; k < LANES; k++) begin
      if (w_lane == IDX_W'(k)) begin
        w_word_nxt[k*LANE_W +: LANE_W] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_word      <= '0;
      r_mask      <= '0;
      r_ptr       <= '0;
    end else begin
      case (r_state)
        S_EMPTY, S_FILL: begin
          if (w_accept) begin
            r_word      <= w_word_nxt;
            r_mask      <= w_mask_nxt;
            r_state     <= w_done ? S_HOLD : S_FILL;
            r_out_valid <= w_done;
            if (!in_mode) begin
              r_ptr <= r_ptr + 1'b1;
            end
          end else if (base_load) begin
            r_word <= base_word;
          end
        end
        S_HOLD: begin
          // The drained word stays in r_word as the next background.
          if (out_ready) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_mask      <= '0;
            r_ptr       <= '0;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef LANE_PACKER_DUP_ERR_EN
  logic r_dup_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dup_err <= 1'b0;
    end else if (w_accept && |(r_mask & w_lane_bit)) begin
      r_dup_err <= 1'b1;
    end
  end

  assign dup_err = r_dup_err;
`else
  assign dup_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lane_packer.sv
`default_nettype none
// Testbench for lane_packer: directed scenarios plus randomized traffic
// against a lane-array reference model; also a 16x8 instance.
module tb_lane_packer;

`ifdef LANE_PACKER_DUP_ERR_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        base_load = 1'b0;
  logic [31:0] base_word = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [1:0]  in_idx = '0;
  logic        in_mode = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [3:0]  out_mask;
  logic        dup_err;

  logic         wb_base_load = 1'b0;
  logic [127:0] wb_base_word = '0;
  logic         wb_in_valid = 1'b0;
  logic         wb_in_ready;
  logic [15:0]  wb_in_data = '0;
  logic [2:0]   wb_in_idx = '0;
  logic         wb_in_mode = 1'b0;
  logic         wb_in_last = 1'b0;
  logic         wb_out_valid;
  logic         wb_out_ready = 1'b0;
  logic [127:0] wb_out_word;
  logic [7:0]   wb_out_mask;
  logic         wb_dup_err;

  lane_packer #(.LANE_W(8), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .base_load(base_load), .base_word(base_word),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_idx(in_idx),
    .in_mode(in_mode), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_mask(out_mask), .dup_err(dup_err)
  );

  lane_packer #(.LANE_W(16), .LANES(8)) dut_wide (
    .clk(clk), .rst_n(rst_n), .base_load(wb_base_load), .base_word(wb_base_word),
    .in_valid(wb_in_valid), .in_ready(wb_in_ready), .in_data(wb_in_data), .in_idx(wb_in_idx),
    .in_mode(wb_in_mode), .in_last(wb_in_last), .out_valid(wb_out_valid), .out_ready(wb_out_ready),
    .out_word(wb_out_word), .out_mask(wb_out_mask), .dup_err(wb_dup_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: an array of lanes, a written flag per lane, a pointer.
  logic [7:0] m_lane [4];
  bit         m_set  [4];
  int         m_ptr;
  bit         m_hold;
  bit         m_dup;

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_lane[k] = 8'h00;
      m_set[k]  = 1'b0;
    end
    m_ptr  = 0;
    m_hold = 1'b0;
    m_dup  = 1'b0;
  endfunction

  function automatic void model_step();
    int  lane;
    bit  all_set;
    if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0;
        m_ptr  = 0;
        for (int k = 0; k < 4; k++) m_set[k] = 1'b0;
      end
    end else begin
      if (base_load) begin
        for (int k = 0; k < 4; k++) m_lane[k] = base_word[k*8 +: 8];
      end
      if (in_valid) begin
        lane = in_mode ? int'(in_idx) : m_ptr;
        if (m_set[lane] && DUP_EN) m_dup = 1'b1;
        m_lane[lane] = in_data;
        m_set[lane]  = 1'b1;
        if (!in_mode) m_ptr = (m_ptr + 1) % 4;
        all_set = 1'b1;
        for (int k = 0; k < 4; k++) all_set &= m_set[k];
        if (all_set || in_last) m_hold = 1'b1;
      end
    end
  endfunction

  function automatic logic [31:0] exp_word();
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[k*8 +: 8] = m_lane[k];
    return w;
  endfunction

  function automatic logic [3:0] exp_mask();
    logic [3:0] m;
    for (int k = 0; k < 4; k++) m[k] = m_set[k];
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic md, input logic [1:0] ix,
                       input logic [7:0] d, input logic lst,
                       input logic bl, input logic [31:0] bw);
    in_valid  = v;
    in_mode   = md;
    in_idx    = ix;
    in_data   = d;
    in_last   = lst;
    base_load = bl;
    base_word = bw;
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    base_load = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, in_ready, dup_err} !== 3'b000 || out_word !== 32'h0 || out_mask !== 4'h0) begin
      failures++;
      $display("FAIL reset_state: valid=%b ready=%b dup=%b word=%h mask=%h, required all 0",
               out_valid, in_ready, dup_err, out_word, out_mask);
    end
    in_valid = 1'b0;
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: got %b required 1", in_ready);
    end
  endtask

  task automatic test_append();
    drive(1, 0, 0, 8'h11, 0, 0, 0);
    drive(1, 0, 0, 8'h22, 0, 0, 0);
    drive(1, 0, 0, 8'h33, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL append_3_not_done: out_valid=%b required 0", out_valid);
    end
    drive(1, 0, 0, 8'h44, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_word !== 32'h44332211 || out_mask !== 4'hF) begin
      failures++;
      $display("FAIL append_word: valid=%b ready=%b word=%h mask=%h, required 1 0 44332211 f",
               out_valid, in_ready, out_word, out_mask);
    end
    drain();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL append_drain: valid=%b ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_insert_base();
    drive(0, 0, 0, 8'h00, 0, 1, 32'hAABBCCDD);
    drive(1, 1, 2, 8'h5A, 1, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_word !== 32'hAA5ACCDD || out_mask !== 4'b0100) begin
      failures++;
      $display("FAIL insert_base: valid=%b word=%h mask=%b, required 1 aa5accdd 0100",
               out_valid, out_word, out_mask);
    end
    drain();
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 4; i++) drive(1, 0, 0, 8'(i), 0, 0, 0);
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    base_load = 1'b1;
    base_word = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_word !== 32'h04030201 || out_mask !== 4'hF) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b word=%h mask=%h, required 1 0 04030201 f",
                 i, out_valid, in_ready, out_word, out_mask);
      end
    end
    in_valid  = 1'b0;
    base_load = 1'b0;
    drain();
    drive(1, 0, 0, 8'h77, 1, 0, 0);
    checks++;
    if (out_word !== 32'h04030277 || out_mask !== 4'b0001) begin
      failures++;
      $display("FAIL backpressure_ptr0: word=%h mask=%b, required 04030277 0001", out_word, out_mask);
    end
    drain();
  endtask

  task automatic test_simultaneous();
    drive(1, 1, 0, 8'hFF, 1, 1, 32'h01020304);
    checks++;
    if (out_valid !== 1'b1 || out_word !== 32'h010203FF || out_mask !== 4'b0001) begin
      failures++;
      $display("FAIL simultaneous: valid=%b word=%h mask=%b, required 1 010203ff 0001",
               out_valid, out_word, out_mask);
    end
    drain();
  endtask

  task automatic test_duplicate();
    drive(1, 1, 1, 8'h10, 0, 0, 0);
    checks++;
    if (dup_err !== 1'b0) begin
      failures++;
      $display("FAIL dup_first: dup_err=%b required 0", dup_err);
    end
    drive(1, 1, 1, 8'h20, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || out_mask !== 4'b0010 || out_word !== 32'h010220FF || dup_err !== DUP_EN) begin
      failures++;
      $display("FAIL dup_second: valid=%b mask=%b word=%h dup=%b, required 0 0010 010220ff %b",
               out_valid, out_mask, out_word, dup_err, DUP_EN);
    end
    drive(1, 1, 1, 8'h20, 1, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_mask !== 4'b0010 || out_word !== 32'h010220FF) begin
      failures++;
      $display("FAIL dup_close: valid=%b mask=%b word=%h, required 1 0010 010220ff",
               out_valid, out_mask, out_word);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_mode   = 1'($urandom_range(0, 1));
      in_idx    = 2'($urandom_range(0, 3));
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 7) == 0);
      base_load = ($urandom_range(0, 7) == 0);
      base_word = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (out_valid !== m_hold || in_ready !== !m_hold || out_word !== exp_word() ||
          out_mask !== exp_mask() || dup_err !== m_dup) begin
        failures++;
        $display("FAIL random[%0d]: valid=%b ready=%b word=%h mask=%b dup=%b, required %b %b %h %b %b",
                 i, out_valid, in_ready, out_word, out_mask, dup_err,
                 m_hold, !m_hold, exp_word(), exp_mask(), m_dup);
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    base_load = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 8'hA1, 0, 0, 0);
    drive(1, 0, 0, 8'hA2, 0, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({out_valid, in_ready, dup_err} !== 3'b000 || out_word !== 32'h0 || out_mask !== 4'h0) begin
      failures++;
      $display("FAIL reset_mid: valid=%b ready=%b dup=%b word=%h mask=%h, required all 0",
               out_valid, in_ready, dup_err, out_word, out_mask);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 8'h99, 1, 0, 0);
    checks++;
    if (out_word !== 32'h00000099 || out_mask !== 4'b0001) begin
      failures++;
      $display("FAIL reset_mid_restart: word=%h mask=%b, required 00000099 0001", out_word, out_mask);
    end
    drain();
  endtask

  task automatic test_wide();
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (wb_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL wide_early_valid[%0d]: got %b required 0", i, wb_out_valid);
      end
      wb_in_valid = 1'b1;
      wb_in_mode  = 1'b0;
      wb_in_data  = 16'(i);
      tick();
    end
    wb_in_valid = 1'b0;
    checks++;
    if (wb_out_valid !== 1'b1 || wb_out_mask !== 8'hFF ||
        wb_out_word !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin
      failures++;
      $display("FAIL wide_word: valid=%b mask=%h word=%h, required 1 ff 00080007000600050004000300020001",
               wb_out_valid, wb_out_mask, wb_out_word);
    end
    wb_out_ready = 1'b1;
    tick();
    wb_out_ready = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_append();
    test_insert_base();
    test_backpressure();
    test_simultaneous();
    test_duplicate();
    test_random();
    test_reset_mid();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
